fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two, >= 2.
REQ-002 Parameter IW, default 32: instruction width.
REQ-003 Parameter PW, default 64: PC width.
REQ-004 Port clk, input, 1: sole clock; all state SHALL update on the rising edge.
REQ-005 Port restart_cpu, input, 1: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1: the fetch stage presents an instruction.
REQ-007 Port in_ready, output, 1: the queue accepts an instruction this cycle.
REQ-008 Port in_instr, input, IW: fetched instruction word.
REQ-009 Port in_pc, input, PW: PC of in_instr.
REQ-010 Port out_valid, output, 1: head entry is available to decode.
REQ-011 Port out_ready, input, 1: decode consumes the head entry this cycle.
REQ-012 Port out_instr, output, IW: head instruction.
REQ-013 Port out_pc, output, PW: head PC.
REQ-014 Port flush, input, 1: taken branch or unconditional branch from execute; discards all queued entries.
REQ-015 Port count, output, $clog2(DEPTH)+1: number of occupied entries.

Function
REQ-016 Push SHALL occur when in_valid && in_ready.
REQ-017 Pop SHALL occur when out_valid && out_ready.
REQ-018 in_ready SHALL be (count != DEPTH) && !flush && !restart_cpu.
- in_ready SHALL have no combinational dependence on out_ready.
REQ-019 out_valid SHALL be (count != 0).
- out_instr and out_pc SHALL be driven to 0 whenever out_valid = 0.
REQ-020 Pushed data SHALL first appear at the outputs in the cycle after the push (latency 1), unless the bypass in REQ-030 applies.
REQ-021 Entries SHALL leave in push order (FIFO).
- Read and write pointers are $clog2(DEPTH) bits and SHALL wrap from DEPTH-1 to 0 with no gap.
REQ-022 A simultaneous push and pop SHALL leave count unchanged.
- When count = DEPTH, in_ready is 0, so no push is possible; a pop in that cycle SHALL decrement count.
REQ-023 While out_valid = 1 and out_ready = 0, out_instr and out_pc SHALL remain stable.
REQ-024 flush SHALL be evaluated at each rising edge.
- Pointers and count SHALL clear on that edge.
- out_valid SHALL be 0 in the next cycle.
- A pop in the flush cycle SHALL be honoured by decode but SHALL have no further effect on queue state.
REQ-025 flush asserted in consecutive cycles SHALL keep the queue empty and in_ready low.
REQ-026 count SHALL never exceed DEPTH and SHALL never underflow.

Reset
REQ-027 On a rising edge with restart_cpu = 1, the block SHALL set read pointer = 0, write pointer = 0, count = 0.
REQ-028 During and after reset, out_valid = 0 and out_instr = out_pc = 0; in_ready SHALL be 0 while restart_cpu = 1 and 1 in the first cycle after it deasserts.
REQ-029 restart_cpu SHALL take priority over flush, push and pop.
- Storage contents need not be reset.

Configuration
REQ-030 Macro FETCH_QUEUE_BYPASS_EN.
- When defined: with count = 0 and a push, out_valid SHALL assert combinationally in the same cycle, with out_instr = in_instr and out_pc = in_pc.
- If out_ready = 1 in that cycle, the entry SHALL NOT be written and count SHALL stay 0.
- Bypass SHALL be suppressed while flush = 1.
- When not defined: latency is exactly 1 cycle per REQ-020 and there is no combinational path from in_* to out_*.

Structure
REQ-031 Package legv8_pkg SHALL hold the following, reused by the fetch and decode stages:
- INSTR_W = 32
- PC_W = 64
- typedef fq_entry_t {pc, instr}
REQ-032 Storage SHALL be a sub-module fq_storage: a DEPTH x fq_entry_t register array with one synchronous write port and one asynchronous read port.
- Pointer, count and handshake logic stay in fetch_queue.

Verification
REQ-033 Reset: hold restart_cpu for 2 cycles with in_valid = 1 -> count = 0, out_valid = 0, out_instr = 0, in_ready = 0 during reset, in_ready = 1 on the next cycle.
REQ-034 Fill and drain: push PC 0x0, 0x4, 0x8, 0xC with out_ready = 0 -> count = 4, in_ready = 0; then out_ready = 1 -> PCs exit in order 0x0, 0x4, 0x8, 0xC, then count = 0.
REQ-035 Wrap-around: run 10 push/pop pairs with PC 0x100 + 4k and DEPTH = 4 -> output order matches input, count stays constant, no entry lost across the pointer wrap.
REQ-036 Flush: with 3 entries queued, assert flush together with in_valid and in_instr = 0x91000421 -> next cycle count = 0, out_valid = 0, and the instruction is never emitted.
REQ-037 Full plus pop: at count = 4 with in_valid = 1 and out_ready = 1 -> in_ready = 0, count becomes 3, and the next-cycle head is the second-oldest entry.
REQ-038 With FETCH_QUEUE_BYPASS_EN defined, empty queue, push 0xD65F03C0 with out_ready = 1 -> out_valid = 1 and out_instr = 0xD65F03C0 in the same cycle, and count stays 0.

Source files
------------

// File: rtl/legv8_pkg.sv
// Shared LEGv8 front-end types: instruction/PC widths and the fetch queue entry.
package legv8_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 64;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fq_storage.sv
// Fetch queue entry storage: DEPTH x fq_entry_t registers, one synchronous
// write port, one asynchronous read port. Contents are not reset.
module fq_storage
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  fq_entry_t     wdata,
  input  logic [AW-1:0] raddr,
  output fq_entry_t     rdata
);

  fq_entry_t mem [DEPTH];

  // Write the addressed entry on a push.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Head entry is read combinationally.
  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue (FIFO) with valid/ready handshakes,
// flush on taken branch and synchronous active-high restart.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to let a push into an empty
// queue reach the outputs in the same cycle.
module fetch_queue
  import legv8_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = INSTR_W,
  parameter int PW    = PC_W
) (
  input  logic                     clk,
  input  logic                     restart_cpu,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IW-1:0]            in_instr,
  input  logic [PW-1:0]            in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out_instr,
  output logic [PW-1:0]            out_pc,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic          push, pop, wr_en;
  fq_entry_t     wr_entry, rd_entry;

  // Acceptance depends only on occupancy, flush and restart (never on out_ready).
  assign in_ready = (count != CW'(DEPTH)) && !flush && !restart_cpu;
  assign push     = in_valid && in_ready;
  // Only stored entries are popped; a bypassed entry never touches state.
  assign pop      = (count != '0) && out_ready;

  // Pack the incoming instruction into a storage entry.
  always_comb begin
    wr_entry                = '0;
    wr_entry.pc[PW-1:0]     = in_pc;
    wr_entry.instr[IW-1:0]  = in_instr;
  end

  // Head outputs, forced to zero when nothing is valid; optional bypass path.
  always_comb begin
    out_valid = (count != '0);
    out_instr = out_valid ? rd_entry.instr[IW-1:0] : '0;
    out_pc    = out_valid ? rd_entry.pc[PW-1:0]    : '0;
    wr_en     = push;
`ifdef FETCH_QUEUE_BYPASS_EN
    // push already excludes flush and restart, so bypass is suppressed then.
    if ((count == '0) && push) begin
      out_valid = 1'b1;
      out_instr = in_instr;
      out_pc    = in_pc;
      // Consumed straight away by decode: nothing to store.
      wr_en     = !out_ready;
    end
`endif
  end

  // Pointer and occupancy state; restart and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (restart_cpu || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_en) - CW'(pop);
    end
  end

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_ptr),
    .rdata (rd_entry)
  );

endmodule

// File: tb/tb_fetch_queue.sv
// Directed, table-driven bench for fetch_queue (DEPTH=4) plus hand-written
// wrap-around and bypass sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        restart_cpu, in_valid, in_ready, out_valid, out_ready, flush;
  logic [31:0] in_instr, out_instr;
  logic [63:0] in_pc, out_pc;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(4), .IW(32), .PW(64)) dut (
    .clk         (clk),
    .restart_cpu (restart_cpu),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc      (out_pc),
    .flush       (flush),
    .count       (count)
  );

  typedef struct {
    logic        rst, iv;
    logic [31:0] instr;
    logic [63:0] pc;
    logic        ordy, fl;
    logic        ir, ov;
    logic [31:0] oi;
    logic [63:0] opc;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic rst, input logic iv, input logic [31:0] instr,
                     input logic [63:0] pc, input logic ordy, input logic fl,
                     input logic ir, input logic ov, input logic [31:0] oi,
                     input logic [63:0] opc, input logic [2:0] cnt);
    vec_t v;
    v.rst = rst; v.iv = iv; v.instr = instr; v.pc = pc; v.ordy = ordy; v.fl = fl;
    v.ir = ir; v.ov = ov; v.oi = oi; v.opc = opc; v.cnt = cnt;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic iv, input logic [31:0] instr,
                       input logic [63:0] pc, input logic ordy, input logic fl);
    restart_cpu = rst; in_valid = iv; in_instr = instr; in_pc = pc;
    out_ready = ordy; flush = fl;
  endtask

  initial begin
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);

    //   rst iv instr         pc      ordy fl | ir ov oi            opc     cnt
    // reset held two cycles with in_valid high
    add(1, 1, 32'h0000_0011, 64'h20,  0, 0,   0, 0, 32'h0,         64'h0,   0);
    add(1, 1, 32'h0000_0011, 64'h20,  0, 0,   0, 0, 32'h0,         64'h0,   0);
    add(0, 0, 32'h0,         64'h0,   0, 0,   1, 0, 32'h0,         64'h0,   0);
    // fill 0x0..0xC with decode stalled; head stays stable
    add(0, 1, 32'hA000_0000, 64'h0,   0, 0,   1, 0, 32'h0,         64'h0,   0);
    add(0, 1, 32'hA000_0004, 64'h4,   0, 0,   1, 1, 32'hA000_0000, 64'h0,   1);
    add(0, 1, 32'hA000_0008, 64'h8,   0, 0,   1, 1, 32'hA000_0000, 64'h0,   2);
    add(0, 1, 32'hA000_000C, 64'hC,   0, 0,   1, 1, 32'hA000_0000, 64'h0,   3);
    add(0, 1, 32'hA000_0010, 64'h10,  0, 0,   0, 1, 32'hA000_0000, 64'h0,   4);
    // drain in order
    add(0, 0, 32'h0,         64'h0,   1, 0,   0, 1, 32'hA000_0000, 64'h0,   4);
    add(0, 0, 32'h0,         64'h0,   1, 0,   1, 1, 32'hA000_0004, 64'h4,   3);
    add(0, 0, 32'h0,         64'h0,   1, 0,   1, 1, 32'hA000_0008, 64'h8,   2);
    add(0, 0, 32'h0,         64'h0,   1, 0,   1, 1, 32'hA000_000C, 64'hC,   1);
    add(0, 0, 32'h0,         64'h0,   0, 0,   1, 0, 32'h0,         64'h0,   0);
    // three queued, then flush (with pop and a new push) twice in a row
    add(0, 1, 32'hB000_0000, 64'h200, 0, 0,   1, 0, 32'h0,         64'h0,   0);
    add(0, 1, 32'hB000_0001, 64'h204, 0, 0,   1, 1, 32'hB000_0000, 64'h200, 1);
    add(0, 1, 32'hB000_0002, 64'h208, 0, 0,   1, 1, 32'hB000_0000, 64'h200, 2);
    add(0, 1, 32'h9100_0421, 64'h20C, 1, 1,   0, 1, 32'hB000_0000, 64'h200, 3);
    add(0, 1, 32'h9100_0421, 64'h20C, 0, 1,   0, 0, 32'h0,         64'h0,   0);
    add(0, 0, 32'h0,         64'h0,   0, 0,   1, 0, 32'h0,         64'h0,   0);
    add(0, 0, 32'h0,         64'h0,   1, 0,   1, 0, 32'h0,         64'h0,   0);
    // fill to 4, then push attempt plus pop at full
    add(0, 1, 32'hC000_0000, 64'h300, 0, 0,   1, 0, 32'h0,         64'h0,   0);
    add(0, 1, 32'hC000_0001, 64'h304, 0, 0,   1, 1, 32'hC000_0000, 64'h300, 1);
    add(0, 1, 32'hC000_0002, 64'h308, 0, 0,   1, 1, 32'hC000_0000, 64'h300, 2);
    add(0, 1, 32'hC000_0003, 64'h30C, 0, 0,   1, 1, 32'hC000_0000, 64'h300, 3);
    add(0, 1, 32'hC000_0004, 64'h310, 1, 0,   0, 1, 32'hC000_0000, 64'h300, 4);
    add(0, 0, 32'h0,         64'h0,   0, 0,   1, 1, 32'hC000_0001, 64'h304, 3);
    // restart wins over push, pop and flush
    add(1, 1, 32'hC000_0005, 64'h314, 1, 1,   0, 1, 32'hC000_0001, 64'h304, 3);
    add(0, 0, 32'h0,         64'h0,   0, 0,   1, 0, 32'h0,         64'h0,   0);

    // one unchecked reset edge so state is defined before the table starts
    @(posedge clk);

    foreach (vt[i]) begin
      vec_t v;
      v = vt[i];
`ifdef FETCH_QUEUE_BYPASS_EN
      // Push into an empty queue is visible in the same cycle.
      if (v.cnt == 0 && v.iv && !v.rst && !v.fl) begin
        v.ov = 1'b1; v.oi = v.instr; v.opc = v.pc;
      end
`endif
      @(negedge clk);
      drive(v.rst, v.iv, v.instr, v.pc, v.ordy, v.fl);
      #1;
      chk($sformatf("v%0d in_ready", i),  64'(in_ready),  64'(v.ir));
      chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(v.ov));
      chk($sformatf("v%0d out_instr", i), 64'(out_instr), 64'(v.oi));
      chk($sformatf("v%0d out_pc", i),    out_pc,         v.opc);
      chk($sformatf("v%0d count", i),     64'(count),     64'(v.cnt));
    end

    // Wrap-around: one entry primed, then 10 push/pop pairs at count 1.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hE000_0100, 64'h100, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 32'hE000_0100 + 32'(4 * k), 64'h100 + 64'(4 * k), 1'b1, 1'b0);
      #1;
      chk($sformatf("wrap%0d pc", k),    out_pc,          64'h100 + 64'(4 * (k - 1)));
      chk($sformatf("wrap%0d instr", k), 64'(out_instr),  64'(32'hE000_0100 + 32'(4 * (k - 1))));
      chk($sformatf("wrap%0d count", k), 64'(count),      64'd1);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    #1;
    chk("wrap last pc", out_pc, 64'h128);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("wrap empty count", 64'(count), 64'd0);
    chk("wrap empty valid", 64'(out_valid), 64'd0);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass with immediate consume: visible now, never stored.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hD65F_03C0, 64'h400, 1'b1, 1'b0);
    #1;
    chk("byp out_valid", 64'(out_valid), 64'd1);
    chk("byp out_instr", 64'(out_instr), 64'hD65F_03C0);
    chk("byp out_pc", out_pc, 64'h400);
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    #1;
    chk("byp count", 64'(count), 64'd0);
    chk("byp after valid", 64'(out_valid), 64'd0);
    // Flush suppresses bypass.
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hD65F_03C0, 64'h404, 1'b1, 1'b1);
    #1;
    chk("byp flush valid", 64'(out_valid), 64'd0);
    chk("byp flush instr", 64'(out_instr), 64'd0);
`endif

    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
